// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared FSM state type and frame constants for the
// SPI master sequencer and its bit timer.
package spi_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   localparam logic RW_READ        = 1'b1;
   localparam int   FRAME_BITS     = 16;
   localparam int   DATA_FIRST_BIT = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// spi_bit_timer: half-period counter and bit index for the SHIFT phase.
// Ports: clk, reset, en (SHIFT active), rise/fall/sample strobes, idx.
module spi_bit_timer
   import spi_master_pkg::*;
#(
   parameter int HALF_PERIOD = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic       rise,
   output logic       fall,
   output logic       sample,
   output logic [3:0] idx
);

   localparam int CW = $clog2(HALF_PERIOD);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] cnt;
   logic          high;
   logic          half_end;

   assign half_end = en && (cnt == HALF_LAST);
   assign rise     = half_end && !high;
   assign fall     = half_end && high;
   // Last cycle of the high half, data byte only.
   assign sample   = fall && (idx >= 4'(DATA_FIRST_BIT));

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt  <= '0;
         high <= 1'b0;
         idx  <= 4'd0;
      end else if (half_end) begin
         cnt  <= '0;
         high <= !high;
         if (high) idx <= idx + 4'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: frames one read/write request as a 16-bit SPI mode-0
// transaction. Ports: req_* handshake in, rsp_* strobe out, SPI pins.
// Option SPI_MASTER_VERIFY_EN: writes are followed by a readback check.
module spi_master_ctrl
   import spi_master_pkg::*;
#(
   parameter int HALF_PERIOD = 16,
   parameter int CS_SETUP    = 16,
   parameter int CS_HOLD     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       verify_err,
   output logic       busy,
   output logic       sclk,
   output logic       cs,
   output logic       mosi,
   input  logic       miso
);

   localparam int PW =
      max_int(1, $clog2(max_int(CS_SETUP, CS_HOLD)));
   localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
   localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);

   state_t                state, next_state;
   logic [PW-1:0]         pcnt;
   logic                  phase_done;
   logic                  rise, fall, sample, last_bit;
   logic [3:0]            idx;
   logic                  sclk_lvl;
   logic [FRAME_BITS-1:0] frame, reload_frame;
   logic [7:0]            rx;
   logic                  write_q, rsp_pend;
   logic                  accept, again, reload;
   logic                  cs_d, sclk_d, mosi_d, ready_d, done_d;
   logic [7:0]            rdata_d;
   logic                  err_d;

   spi_bit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .en     (state == SHIFT),
      .rise   (rise),
      .fall   (fall),
      .sample (sample),
      .idx    (idx)
   );

   assign accept     = req_valid && req_ready;
   assign phase_done = (state == SETUP) ? (pcnt == SETUP_LAST)
                                        : (pcnt == HOLD_LAST);
   assign last_bit   = fall && (idx == 4'(FRAME_BITS - 1));
   assign reload     = (state == GAP) && phase_done && again;

`ifdef SPI_MASTER_VERIFY_EN
   logic       vpass;
   logic [6:0] addr_q;
   logic [7:0] wdata_q;

   assign again        = write_q && !vpass;
   assign reload_frame = {addr_q, RW_READ, 8'h00};
   assign rdata_d      = rx;
   assign err_d        = write_q && (rx != wdata_q);

   always_ff @(posedge clk) begin
      if (reset)       vpass <= 1'b0;
      else if (accept) vpass <= 1'b0;
      else if (reload) vpass <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end
`else
   assign again        = 1'b0;
   assign reload_frame = frame;
   assign rdata_d      = write_q ? 8'h00 : rx;
   assign err_d        = 1'b0;
`endif

   // Datapath: frame capture and miso shift-in.
   always_ff @(posedge clk) begin
      if (accept) begin
         write_q <= req_write;
         frame   <= {req_addr,
                     req_write ? ~RW_READ : RW_READ,
                     req_write ? req_wdata : 8'h00};
      end else if (reload) begin
         frame <= reload_frame;
      end
      if (sample) rx <= {rx[6:0], miso};
   end

   // Phase counter restarts on every state change.
   always_ff @(posedge clk) begin
      if (reset || (state != next_state)) pcnt <= '0;
      else                                pcnt <= pcnt + PW'(1);
   end

   // sclk level inside SHIFT, one cycle ahead of the pin.
   always_ff @(posedge clk) begin
      if (reset || (state != SHIFT)) sclk_lvl <= 1'b0;
      else if (rise)                 sclk_lvl <= 1'b1;
      else if (fall)                 sclk_lvl <= 1'b0;
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cs         <= 1'b1;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         rsp_pend   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 8'h00;
         verify_err <= 1'b0;
      end else begin
         state     <= next_state;
         cs        <= cs_d;
         sclk      <= sclk_d;
         mosi      <= mosi_d;
         req_ready <= ready_d;
         busy      <= !ready_d;
         rsp_pend  <= done_d;
         rsp_valid <= rsp_pend;
         if (rsp_pend) begin
            rsp_rdata  <= rdata_d;
            verify_err <= err_d;
         end
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (accept)     next_state = SETUP;
         SETUP:   if (phase_done) next_state = SHIFT;
         SHIFT:   if (last_bit)   next_state = HOLD;
         HOLD:    if (phase_done) next_state = GAP;
         GAP:     if (phase_done) next_state = again ? SETUP : IDLE;
         default:                 next_state = IDLE;
      endcase
   end

   always_comb begin
      cs_d   = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      unique case (state)
         SETUP: begin
            cs_d   = 1'b0;
            mosi_d = frame[FRAME_BITS-1];
         end
         SHIFT: begin
            cs_d   = 1'b0;
            sclk_d = sclk_lvl;
            mosi_d = frame[4'(FRAME_BITS - 1) - idx];
         end
         HOLD:    cs_d = 1'b0;
         default: ;
      endcase
      ready_d = (next_state == IDLE);
      done_d  = (state == GAP) && (next_state == IDLE);
   end

endmodule
